// File: rtl/output_display_if.sv
// Bundle between the CPU output register and the 7-segment display driver.
// The master side drives the load strobe and data, and the slave side returns the display and result.
interface output_display_if;
  logic        load;
  logic [7:0]  value;
  logic        mode;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [11:0] bcd;
  logic        neg;
  logic        busy;

  modport master (output load, value, mode, input seg, an, bcd, neg, busy);
  modport slave  (input load, value, mode, output seg, an, bcd, neg, busy);
endinterface

// File: rtl/output_display.sv
// Captures an 8-bit output value, converts it to BCD with a one-shift-per-clock double dabble,
// and scans the result (sign, hundreds, tens, ones) onto a 4-digit 7-segment display.
module output_display #(
  parameter int SCAN_DIV     = 1000,
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  output_display_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  state_t      state_q;
  logic [19:0] work_q;
  logic        neg_work_q;
  logic [3:0]  iter_q;
  logic        pend_valid_q;
  logic [7:0]  pend_value_q;
  logic        pend_mode_q;
  logic [11:0] bcd_q;
  logic        neg_q;
  logic        busy_q;

  logic [15:0] scan_q, scan_d;
  logic [1:0]  digit_q, digit_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;

  // In DONE a fresh load takes priority over the pending entry.
  logic        start_from_pend;
  logic [7:0]  start_value;
  logic        start_mode;
  logic        start_neg;
  logic [8:0]  start_mag;

  assign start_from_pend = (state_q == DONE) && !bus.load;
  assign start_value     = start_from_pend ? pend_value_q : bus.value;
  assign start_mode      = start_from_pend ? pend_mode_q  : bus.mode;
  assign start_neg       = start_mode && start_value[7];
  assign start_mag       = start_neg ? (9'd256 - {1'b0, start_value}) : {1'b0, start_value};

  logic [11:0] adj;
  logic [19:0] shifted;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (work_q[8 + gi*4 +: 4] >= 4'd5) ? work_q[8 + gi*4 +: 4] + 4'd3
                                                               : work_q[8 + gi*4 +: 4];
    end
  endgenerate

  assign shifted = {adj[10:0], work_q[7:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      work_q       <= '0;
      neg_work_q   <= 1'b0;
      iter_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_value_q <= '0;
      pend_mode_q  <= 1'b0;
      bcd_q        <= '0;
      neg_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.load) begin
            state_q    <= CONV;
            work_q     <= {11'd0, start_mag};
            neg_work_q <= start_neg;
            iter_q     <= '0;
            busy_q     <= 1'b1;
          end
        end
        CONV: begin
          work_q <= shifted;
          iter_q <= iter_q + 4'd1;
          if (iter_q == 4'd7) state_q <= DONE;
          if (bus.load) begin
            pend_valid_q <= 1'b1;
            pend_value_q <= bus.value;
            pend_mode_q  <= bus.mode;
          end
        end
        DONE: begin
          bcd_q <= work_q[19:8];
          neg_q <= neg_work_q;
          if (bus.load || pend_valid_q) begin
            state_q      <= CONV;
            work_q       <= {11'd0, start_mag};
            neg_work_q   <= start_neg;
            iter_q       <= '0;
            pend_valid_q <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  function automatic logic [6:0] hex7(logic [3:0] d);
    unique case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // seg/an are computed from the next digit index so they change on the same edge as the index.
  always_comb begin
    scan_d  = scan_q + 16'd1;
    digit_d = digit_q;
    if (scan_q == SCAN_LAST) begin
      scan_d  = '0;
      digit_d = digit_q + 2'd1;
    end
    an_d  = 4'b0001 << digit_d;
    seg_d = 7'b0000000;
    unique case (digit_d)
      2'd0: seg_d = hex7(bcd_q[3:0]);
      2'd1: seg_d = (bcd_q[11:4] == 8'd0) ? 7'b0000000 : hex7(bcd_q[7:4]);
      2'd2: seg_d = (bcd_q[11:8] == 4'd0) ? 7'b0000000 : hex7(bcd_q[11:8]);
      2'd3: seg_d = neg_q ? 7'b1000000 : 7'b0000000;
      default: seg_d = 7'b0000000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q  <= '0;
      digit_q <= '0;
      seg_q   <= 7'b0111111;
      an_q    <= 4'b0001;
    end else begin
      scan_q  <= scan_d;
      digit_q <= digit_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign bus.seg  = seg_q ^ {7{COMMON_ANODE}};
  assign bus.an   = an_q  ^ {4{COMMON_ANODE}};
  assign bus.bcd  = bcd_q;
  assign bus.neg  = neg_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_output_display.sv
// Self-checking bench for output_display: directed and randomized loads checked against a
// decimal-arithmetic reference, plus scan-sequence checks on an active-high and an inverted instance.
module tb_output_display;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  output_display_if if0();
  output_display_if if1();

  output_display #(.SCAN_DIV(4), .COMMON_ANODE(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  output_display #(.SCAN_DIV(4), .COMMON_ANODE(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int          vectors    = 0;
  int          miscompares = 0;
  logic [11:0] prev_bcd   = '0;
  logic        prev_neg   = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic l, logic [7:0] v, logic m);
    if0.load = l; if0.value = v; if0.mode = m;
    if1.load = l; if1.value = v; if1.mode = m;
  endtask

  function automatic logic [11:0] ref_bcd(logic [7:0] v, logic m);
    int mag;
    mag = (m && v[7]) ? 256 - int'(v) : int'(v);
    return {4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
  endfunction

  function automatic logic ref_neg(logic [7:0] v, logic m);
    return m && v[7];
  endfunction

  function automatic logic [6:0] hex7(int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;  4: return 7'h66;
      5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;  8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(int pos, logic [11:0] b, logic n);
    int h, t, o;
    h = int'(b[11:8]); t = int'(b[7:4]); o = int'(b[3:0]);
    case (pos)
      0: return hex7(o);
      1: return (h == 0 && t == 0) ? 7'h00 : hex7(t);
      2: return (h == 0) ? 7'h00 : hex7(h);
      default: return n ? 7'h40 : 7'h00;
    endcase
  endfunction

  task automatic chk_result(string tag, logic [11:0] eb, logic en);
    chk({tag, "_bcd"}, 32'(if0.bcd), 32'(eb));
    chk({tag, "_neg"}, 32'(if0.neg), 32'(en));
    chk({tag, "_bcd_ca"}, 32'(if1.bcd), 32'(eb));
  endtask

  // One load from idle: busy after E0..E8, result and busy low after E9.
  task automatic convert(string tag, logic [7:0] v, logic m);
    drive(1'b1, v, m);
    step();
    drive(1'b0, 8'h00, 1'b0);
    chk({tag, "_busy_E0"}, 32'(if0.busy), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk({tag, "_busy_conv"}, 32'(if0.busy), 32'd1);
      chk({tag, "_hold"}, 32'(if0.bcd), 32'(prev_bcd));
    end
    step();
    chk({tag, "_busy_E9"}, 32'(if0.busy), 32'd0);
    prev_bcd = ref_bcd(v, m);
    prev_neg = ref_neg(v, m);
    chk_result(tag, prev_bcd, prev_neg);
  endtask

  // Load v0 at E0, v1 at E t1 (1..9), optional v2 at E t2 (t1 < t2 <= 8). Newest load wins.
  task automatic run_pair(string tag, logic [7:0] v0, logic m0, int t1, logic [7:0] v1, logic m1,
                          int t2, logic [7:0] v2, logic m2);
    logic [11:0] first_b, second_b;
    logic        second_n;
    first_b  = ref_bcd(v0, m0);
    second_b = (t2 != 0) ? ref_bcd(v2, m2) : ref_bcd(v1, m1);
    second_n = (t2 != 0) ? ref_neg(v2, m2) : ref_neg(v1, m1);
    for (int cyc = 0; cyc <= 18; cyc++) begin
      if (cyc == 0)                  drive(1'b1, v0, m0);
      else if (cyc == t1)            drive(1'b1, v1, m1);
      else if (t2 != 0 && cyc == t2) drive(1'b1, v2, m2);
      else                           drive(1'b0, 8'h00, 1'b0);
      step();
      chk({tag, "_busy"}, 32'(if0.busy), (cyc < 18) ? 32'd1 : 32'd0);
      if (cyc < 9)       chk({tag, "_bcd_pre"},  32'(if0.bcd), 32'(prev_bcd));
      else if (cyc < 18) chk({tag, "_bcd_mid"},  32'(if0.bcd), 32'(first_b));
      else               chk({tag, "_bcd_last"}, 32'(if0.bcd), 32'(second_b));
    end
    drive(1'b0, 8'h00, 1'b0);
    prev_bcd = second_b;
    prev_neg = second_n;
    chk({tag, "_neg"}, 32'(if0.neg), 32'(second_n));
  endtask

  // Sync on the sign->ones transition, then check one full scan of both instances.
  task automatic check_display(string tag, logic [11:0] b, logic n);
    logic [3:0] prev_an;
    int         guard;
    guard   = 0;
    prev_an = if0.an;
    step();
    while (!(prev_an == 4'b1000 && if0.an == 4'b0001) && guard < 40) begin
      prev_an = if0.an;
      step();
      guard++;
    end
    chk({tag, "_scan_sync"}, (guard < 40) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_an"},     32'(if0.an),  32'(4'b0001 << (i / 4)));
      chk({tag, "_seg"},    32'(if0.seg), 32'(exp_seg(i / 4, b, n)));
      chk({tag, "_an_ca"},  32'(if1.an),  32'((4'b0001 << (i / 4)) ^ 4'hF));
      chk({tag, "_seg_ca"}, 32'(if1.seg), 32'(exp_seg(i / 4, b, n) ^ 7'h7F));
      step();
    end
  endtask

  initial begin
    logic [7:0] rv;
    logic       rm;
    int         t1, t2;

    drive(1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    repeat (6) step();

    // Asynchronous reset in the middle of a scan.
    rst_n = 1'b0;
    #1;
    chk("rst_an",     32'(if0.an),   32'h1);
    chk("rst_seg",    32'(if0.seg),  32'h3F);
    chk("rst_an_ca",  32'(if1.an),   32'hE);
    chk("rst_seg_ca", 32'(if1.seg),  32'h40);
    chk("rst_bcd",    32'(if0.bcd),  32'h000);
    chk("rst_busy",   32'(if0.busy), 32'd0);
    chk("rst_neg",    32'(if0.neg),  32'd0);
    step();
    rst_n = 1'b1;
    step();

    convert("u_ff", 8'hFF, 1'b0);
    chk("u_ff_const", 32'(if0.bcd), 32'h255);
    convert("s_80", 8'h80, 1'b1);
    chk("s_80_const", 32'(if0.bcd), 32'h128);
    check_display("disp_s80", prev_bcd, prev_neg);
    convert("s_f6", 8'hF6, 1'b1);
    chk("s_f6_const", 32'(if0.bcd), 32'h010);
    check_display("disp_sf6", prev_bcd, prev_neg);
    convert("u_123", 8'd123, 1'b0);
    check_display("disp_123", prev_bcd, prev_neg);

    run_pair("pend_579", 8'h05, 1'b0, 3, 8'h07, 1'b0, 5, 8'h09, 1'b0);
    chk("pend_579_const", 32'(if0.bcd), 32'h009);
    run_pair("pend_last_shift", 8'h2A, 1'b0, 8, 8'hC8, 1'b1, 0, 8'h00, 1'b0);
    run_pair("done_edge_load", 8'h64, 1'b0, 9, 8'h81, 1'b1, 0, 8'h00, 1'b0);

    for (int k = 0; k < 16; k++) begin
      rv = 8'($urandom_range(0, 255));
      rm = 1'($urandom_range(0, 1));
      convert("rand_single", rv, rm);
      if (k % 4 == 3) check_display("rand_disp", prev_bcd, prev_neg);
    end

    for (int k = 0; k < 8; k++) begin
      t1 = int'($urandom_range(1, 9));
      t2 = (t1 < 8) ? int'($urandom_range(0, 1)) * int'($urandom_range(t1 + 1, 8)) : 0;
      run_pair("rand_pair", 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), t1,
               8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), t2,
               8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    // Reset during a conversion aborts it with no commit.
    drive(1'b1, 8'hFF, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(if0.busy), 32'd0);
    chk("abort_bcd",  32'(if0.bcd),  32'h000);
    step();
    rst_n = 1'b1;
    repeat (12) step();
    chk("abort_bcd_after",  32'(if0.bcd),  32'h000);
    chk("abort_busy_after", 32'(if0.busy), 32'd0);
    chk("abort_neg_after",  32'(if0.neg),  32'd0);
    prev_bcd = '0;
    prev_neg = 1'b0;
    check_display("disp_zero", prev_bcd, prev_neg);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
